// File: rtl/mar_ram.sv
// rtl/mar_ram.sv - MAR-addressed single-port bus memory with post-increment and hardware clear
module mar_ram #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 12,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ram_en,
  input  logic              mar_load,
  input  logic              ram_load,
  input  logic              mar_inc,
  input  logic              clr_req,
  input  logic [DATA_W-1:0] bus,
  output logic [DATA_W-1:0] out,
  output logic              out_valid,
  output logic              busy,
  output logic              addr_err
);

  // Index width of the implemented array; at least one bit so DEPTH=1 still elaborates.
  localparam int CNT_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // DEPTH widened by one bit so DEPTH == 2^ADDR_W still compares correctly against mar.
  localparam logic [ADDR_W:0]   DEPTH_V  = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_MAR = ADDR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(DEPTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  clr_cnt;
  logic [ADDR_W-1:0] mar;

  // Array has no reset; the declaration initialiser only gives simulation a zeroed start.
  logic [DATA_W-1:0] mem [DEPTH] = '{default: '0};

  logic              idle;
  logic              in_range;
  logic [CNT_W-1:0]  mar_idx;
  logic              do_clr;
  logic              do_read;
  logic              do_mload;
  logic              do_write;
  logic              do_inc;
  logic [ADDR_W-1:0] mar_inc_val;
  logic [DATA_W-1:0] rd_data;
  logic              mem_we;
  logic [CNT_W-1:0]  mem_waddr;
  logic [DATA_W-1:0] mem_wdata;

  // Command decode: one command per cycle, clr_req > ram_en > mar_load > ram_load, IDLE only.
  always_comb begin
    idle        = (state == IDLE);
    in_range    = ({1'b0, mar} < DEPTH_V);
    mar_idx     = mar[CNT_W-1:0];
    do_clr      = idle & clr_req;
    do_read     = idle & ~clr_req & ram_en;
    do_mload    = idle & ~clr_req & ~ram_en & mar_load;
    do_write    = idle & ~clr_req & ~ram_en & ~mar_load & ram_load;
    // Increment rides only on an accepted read/write and never moves an out-of-range mar.
    do_inc      = mar_inc & in_range & (do_read | do_write);
    mar_inc_val = (mar == LAST_MAR) ? '0 : mar + ADDR_W'(1);
    rd_data     = in_range ? mem[mar_idx] : '0;
  end

  // Single write port shared by the clear sequencer and bus writes; out-of-range writes drop.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = mar_idx;
    mem_wdata = bus;
    if (state == CLEAR) begin
      mem_we    = 1'b1;
      mem_waddr = clr_cnt;
      mem_wdata = '0;
    end else if (do_write && in_range) begin
      mem_we = 1'b1;
    end
  end

  // Memory array write.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  // Clear sequencer: one word per cycle from 0 to DEPTH-1, then back to IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      clr_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (do_clr) begin
            state   <= CLEAR;
            clr_cnt <= '0;
          end
        end
        CLEAR: begin
          if (clr_cnt == LAST_CNT) begin
            state   <= IDLE;
            clr_cnt <= '0;
          end else begin
            clr_cnt <= clr_cnt + CNT_W'(1);
          end
        end
        default: begin
          state   <= IDLE;
          clr_cnt <= '0;
        end
      endcase
    end
  end

  // MAR update and registered read data; out holds between reads and across clears.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mar       <= '0;
      out       <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= do_read;
      if (do_read) begin
        out <= rd_data;
      end
      if (do_mload) begin
        mar <= bus[ADDR_W-1:0];
      end else if (do_inc) begin
        mar <= mar_inc_val;
      end
    end
  end

  assign busy     = (state == CLEAR);
  assign addr_err = ~in_range;

endmodule

// File: tb/tb_mar_ram.sv
// tb/tb_mar_ram.sv - scoreboard testbench for mar_ram
module tb_mar_ram;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 12;
  localparam int DEPTH  = 256;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              ram_en;
  logic              mar_load;
  logic              ram_load;
  logic              mar_inc;
  logic              clr_req;
  logic [DATA_W-1:0] bus;
  logic [DATA_W-1:0] out;
  logic              out_valid;
  logic              busy;
  logic              addr_err;

  mar_ram #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W),
    .DEPTH (DEPTH)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ram_en   (ram_en),
    .mar_load (mar_load),
    .ram_load (ram_load),
    .mar_inc  (mar_inc),
    .clr_req  (clr_req),
    .bus      (bus),
    .out      (out),
    .out_valid(out_valid),
    .busy     (busy),
    .addr_err (addr_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: plain array memory, integer MAR, clear as a remaining-cycle count.
  int m_mem [DEPTH];
  int m_mar;
  int m_out;
  int m_clear_left;
  int exp_q [$];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every out_valid cycle consumes exactly one expected read.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && out_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_out_valid: got out_valid=1 out=0x%0h expected no read pending", out);
      end else begin
        check("read_data", int'(out), exp_q.pop_front());
      end
    end
  end

  // One bus cycle: drive inputs, advance the model, clock, then check busy/addr_err.
  task automatic step(input logic en, input logic ml, input logic rl, input logic inc,
                      input logic clr, input logic [DATA_W-1:0] b);
    int e;
    ram_en   = en;
    mar_load = ml;
    ram_load = rl;
    mar_inc  = inc;
    clr_req  = clr;
    bus      = b;
    if (m_clear_left > 0) begin
      m_clear_left--;
    end else if (clr) begin
      m_clear_left = DEPTH;
      foreach (m_mem[i]) m_mem[i] = 0;
    end else if (en) begin
      e = (m_mar < DEPTH) ? m_mem[m_mar] : 0;
      exp_q.push_back(e);
      m_out = e;
      if (inc && m_mar < DEPTH) m_mar = (m_mar + 1) % DEPTH;
    end else if (ml) begin
      m_mar = int'(b) % (1 << ADDR_W);
    end else if (rl) begin
      if (m_mar < DEPTH) begin
        m_mem[m_mar] = int'(b);
        if (inc) m_mar = (m_mar + 1) % DEPTH;
      end
    end
    @(posedge clk);
    #1;
    check("busy", int'(busy), int'(m_clear_left > 0));
    check("addr_err", int'(addr_err), int'(m_mar >= DEPTH));
  endtask

  task automatic idle_cyc();
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
  endtask

  task automatic load(input logic [DATA_W-1:0] a);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, a);
  endtask

  task automatic wr(input logic [DATA_W-1:0] d, input logic inc);
    step(1'b0, 1'b0, 1'b1, inc, 1'b0, d);
  endtask

  task automatic rd(input logic inc);
    step(1'b1, 1'b0, 1'b0, inc, 1'b0, '0);
  endtask

  initial begin
    int r;
    logic [DATA_W-1:0] b;
    rst_n    = 1'b0;
    ram_en   = 1'b0;
    mar_load = 1'b0;
    ram_load = 1'b0;
    mar_inc  = 1'b0;
    clr_req  = 1'b0;
    bus      = '0;
    foreach (m_mem[i]) m_mem[i] = 0;
    m_mar        = 0;
    m_out        = 0;
    m_clear_left = 0;

    #12;
    check("reset_out", int'(out), 0);
    check("reset_out_valid", int'(out_valid), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_addr_err", int'(addr_err), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic write then read, out_valid exactly one cycle.
    load(16'h000D);
    wr(16'hBEEF, 1'b0);
    rd(1'b0);
    check("t1_valid_high", int'(out_valid), 1);
    check("t1_out", int'(out), 16'hBEEF);
    idle_cyc();
    check("t1_valid_low", int'(out_valid), 0);
    check("t1_out_hold", int'(out), 16'hBEEF);

    // Block write with wrap at DEPTH.
    load(16'h00FE);
    wr(16'h1111, 1'b1);
    wr(16'h2222, 1'b1);
    rd(1'b0);
    load(16'h00FE);
    rd(1'b1);
    rd(1'b1);

    // Out of range: no write, zero reads, no increment, no aliasing onto word 0.
    load(16'h0000);
    wr(16'h5A5A, 1'b0);
    load(16'h0100);
    wr(16'hAAAA, 1'b0);
    rd(1'b0);
    rd(1'b1);
    wr(16'hAAAA, 1'b1);
    rd(1'b0);
    load(16'h0000);
    rd(1'b0);

    // Priority: read beats MAR load and write.
    load(16'h0003);
    wr(16'h3333, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0005);
    rd(1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0007);
    rd(1'b0);

    // Randomised command mix against the model.
    for (int i = 0; i < 600; i++) begin
      r = $urandom_range(0, 9);
      b = (r < 8) ? DATA_W'($urandom_range(0, 16'h010F)) : DATA_W'($urandom);
      step(1'($urandom_range(0, 9) < 4), 1'($urandom_range(0, 9) < 3),
           1'($urandom_range(0, 9) < 4), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 299) == 0), b);
    end
    while (m_clear_left > 0) idle_cyc();

    // Full clear: fill, clear with commands thrown at it, then read everything back.
    load(16'h0000);
    for (int i = 0; i < DEPTH; i++) wr(DATA_W'(i + 1), 1'b1);
    load(16'h0005);
    rd(1'b0);
    load(16'h01A0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, '0);
    for (int i = 0; i < DEPTH; i++) begin
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), DATA_W'($urandom_range(0, 255)));
    end
    check("clear_out_hold", int'(out), m_out);
    rd(1'b0);
    load(16'h0000);
    for (int i = 0; i < DEPTH; i++) rd(1'b1);

    // Reset in the middle of a clear drops everything asynchronously.
    load(16'h0120);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, '0);
    for (int i = 0; i < 99; i++) idle_cyc();
    rst_n = 1'b0;
    #1;
    check("midclr_busy", int'(busy), 0);
    check("midclr_out", int'(out), 0);
    check("midclr_out_valid", int'(out_valid), 0);
    check("midclr_addr_err", int'(addr_err), 0);
    m_mar        = 0;
    m_out        = 0;
    m_clear_left = 0;
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, '0);
    for (int i = 0; i < DEPTH; i++) idle_cyc();
    load(16'h00F8);
    for (int i = 0; i < 16; i++) rd(1'b1);
    wr(16'h7777, 1'b0);
    rd(1'b0);

    idle_cyc();
    @(negedge clk);
    #1;
    check("queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mar_ram.md
# mar_ram

Parametrised successor to the single-port, MAR-addressed, bus-attached program/data memory of the MEH16 CPU. It keeps the existing command set (read, MAR load, write) and its priority order. It adds configurable data/address width and depth, a post-increment addressing mode for block transfers, and an out-of-range address flag. It also adds a hardware clear sequencer that zeroes the whole array. It sits on the CPU bus between the control unit and the datapath registers.

## Interface
- DATA_W, 16, word width of bus, memory and out
- ADDR_W, 12, MAR width; MAR loads from bus[ADDR_W-1:0]
- DEPTH, 256, number of implemented words; legal range 1..2^ADDR_W
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- ram_en  in  1  read mem[mar] into out
- mar_load  in  1  load MAR from bus
- ram_load  in  1  write bus into mem[mar]
- mar_inc  in  1  post-increment MAR after a read or write in the same cycle
- clr_req  in  1  start clearing the whole array to zero
- bus  in  DATA_W  shared CPU bus
- out  out  DATA_W  registered read data
- out_valid  out  1  high for one cycle after each accepted read
- busy  out  1  high while the clear sequencer runs
- addr_err  out  1  high while mar >= DEPTH

## Operation
- Registers: mar[ADDR_W-1:0], out, out_valid, the FSM state {IDLE, CLEAR} and clr_cnt. The memory array is not reset and is zero-initialised for simulation.
- Reset values: mar=0, out=0, out_valid=0, busy=0, addr_err=0, state=IDLE, clr_cnt=0.
- Commands are sampled only in IDLE. Priority is clr_req > ram_en > mar_load > ram_load, and exactly one command is acted on per cycle.
- Read (ram_en):
  - out <= mem[mar]; out_valid <= 1.
  - If mar >= DEPTH, out <= 0 and addr_err stays set.
- MAR load (mar_load): mar <= bus[ADDR_W-1:0].
- Write (ram_load): mem[mar] <= bus. If mar >= DEPTH, the write is dropped and memory is unchanged.
- Post-increment (mar_inc):
  - Acts only together with an accepted read or write; otherwise it is ignored.
  - mar <= (mar == DEPTH-1) ? 0 : mar+1, so it wraps at DEPTH.
  - An out-of-range mar is not incremented.
- out_valid is 0 in every cycle that does not follow an accepted read. out holds its last value.
- addr_err is combinational from the registered mar: (mar >= DEPTH).
- FSM:
  - IDLE -> CLEAR on clr_req; clr_cnt <= 0.
  - CLEAR: each cycle mem[clr_cnt] <= 0 and clr_cnt increments.
  - The cycle with clr_cnt == DEPTH-1 returns to IDLE.
  - busy = (state == CLEAR).
  - mar and out are untouched by a clear.
- While in CLEAR, ram_en, mar_load, ram_load, mar_inc and clr_req are ignored and not queued. out_valid stays 0.
- Reset mid-clear: state returns to IDLE and busy drops immediately, asynchronously. Array contents are then undefined and must be re-cleared by software.

## Timing
- Read latency is 1 cycle: ram_en sampled at edge N gives out and out_valid valid after edge N, until edge N+1.
- Write-then-read of the same address: a read accepted the cycle after the write returns the new data. There is no read-during-write case because commands are exclusive.
- mar_load followed by ram_en in the next cycle reads the newly loaded address.
- Clear:
  - clr_req sampled at edge E0 raises busy after E0.
  - Array writes occur at E1..E_DEPTH; busy is high for exactly DEPTH cycles.
  - busy is low after E_DEPTH, and a command presented in that cycle is accepted at E_DEPTH+1.
- Simultaneous ram_en+mar_load: only the read happens and mar is unchanged.
- Simultaneous ram_en+ram_load: only the read happens and memory is unchanged.

## Test plan
- Reset, then DATA_W=16/ADDR_W=12/DEPTH=256: mar_load bus=0x00D; ram_load bus=0xBEEF; ram_en -> out=0xBEEF, with out_valid for exactly one cycle, 1 cycle after ram_en.
- Block write with mar_inc: mar_load 0x0FE, then two ram_load+mar_inc writes of 0x1111 and 0x2222 -> mar wraps to 0x000. Reading back 0x0FE and 0x0FF returns 0x1111 and 0x2222.
- Out of range: mar_load 0x100 -> addr_err=1. ram_load 0xAAAA leaves memory unchanged; ram_en gives out=0 and out_valid=1. mar_inc leaves mar at 0x100.
- Priority: ram_en+mar_load+ram_load with bus=0x0005 at mar=3 -> out=mem[3], mar stays 3, mem[3] unchanged.
- Clear: fill words 0..255 with nonzero values, then pulse clr_req -> busy high for 256 cycles and commands during busy are ignored. Afterwards every read returns 0, and mar and out are unchanged.
- Reset mid-clear: assert rst_n=0 at clear cycle 100 -> busy=0, mar=0, out=0 and out_valid=0 immediately, without waiting for a clock edge. A new clr_req then completes normally.
